// File: rtl/port_timer_irq_if.sv
// Processor port bus as seen by the timer: port_id, strobes, write/read data,
// interrupt request and acknowledge.
interface port_timer_irq_if;
   logic [7:0] address;
   logic [7:0] value_in;
   logic [7:0] value_out;
   logic       wen;
   logic       ren;
   logic       iak;
   logic       irq;

   modport master (
      output address, value_in, wen, ren, iak,
      input  value_out, irq
   );

   modport slave (
      input  address, value_in, wen, ren, iak,
      output value_out, irq
   );
endinterface

// File: rtl/port_timer_irq.sv
// Port-mapped prescaled down-counting timer with a latched, acknowledgeable
// interrupt. Registers: CTRL, RELOAD, PRESC, STATUS at BASE..BASE+3.
module port_timer_irq #(
   parameter logic [7:0] BASE    = 8'h10,
   parameter int         PRESC_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   port_timer_irq_if.slave bus
);

   logic [7:0]         offset;
   logic               hit;
   logic               wr_ctrl, wr_reload, wr_presc, wr_status;
   logic               en, ie, oneshot;
   logic [7:0]         reload;
   logic [PRESC_W-1:0] presc;
   logic [PRESC_W-1:0] presc_cnt;
   logic [7:0]         count;
   logic               pend, ovr;
   logic               irq_q;
   logic [7:0]         rd_data;
   logic [7:0]         value_out_q;
   logic               tick, expire, start, pend_clr, ovr_clr;
   logic               unused_ren;

   assign offset     = bus.address - BASE;
   assign hit        = (offset[7:2] == 6'd0);
   assign wr_ctrl    = bus.wen & hit & (offset[1:0] == 2'd0);
   assign wr_reload  = bus.wen & hit & (offset[1:0] == 2'd1);
   assign wr_presc   = bus.wen & hit & (offset[1:0] == 2'd2);
   assign wr_status  = bus.wen & hit & (offset[1:0] == 2'd3);
   assign unused_ren = bus.ren;

   assign tick     = en & (presc_cnt == presc);
   assign expire   = tick & (count == 8'd0);
   assign start    = wr_ctrl & bus.value_in[0] & ~en;
   assign pend_clr = bus.iak | (wr_status & bus.value_in[0]);
   assign ovr_clr  = wr_status & bus.value_in[1];

   // A CTRL write on the one-shot expiry edge overrides the automatic EN clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en      <= 1'b0;
         ie      <= 1'b0;
         oneshot <= 1'b0;
         reload  <= 8'hFF;
         presc   <= '0;
      end else begin
         if (expire && oneshot)
            en <= 1'b0;
         if (wr_ctrl) begin
            en      <= bus.value_in[0];
            ie      <= bus.value_in[1];
            oneshot <= bus.value_in[2];
         end
         if (wr_reload)
            reload <= bus.value_in;
         if (wr_presc)
            presc <= PRESC_W'(bus.value_in);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count     <= 8'hFF;
         presc_cnt <= '0;
      end else if (start) begin
         count     <= reload;
         presc_cnt <= '0;
      end else if (en) begin
         if (tick) begin
            presc_cnt <= '0;
            count     <= (count == 8'd0) ? reload : count - 8'd1;
         end else begin
            presc_cnt <= presc_cnt + 1'b1;
         end
      end
   end

   // Expiry beats a coincident clear; such an expiry also leaves OVR alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend  <= 1'b0;
         ovr   <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         if (expire)
            pend <= 1'b1;
         else if (pend_clr)
            pend <= 1'b0;
         if (expire && pend && !pend_clr)
            ovr <= 1'b1;
         else if (ovr_clr)
            ovr <= 1'b0;
         irq_q <= pend & ie;
      end
   end

   always_comb begin
      rd_data = 8'h00;
      if (hit) begin
         case (offset[1:0])
            2'd0:    rd_data = {5'd0, oneshot, ie, en};
            2'd1:    rd_data = reload;
            2'd2:    rd_data = 8'(presc);
            default: rd_data = {6'd0, ovr, pend};
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         value_out_q <= 8'h00;
      else
         value_out_q <= rd_data;
   end

   assign bus.value_out = value_out_q;
   assign bus.irq       = irq_q;

endmodule
